// File: rtl/dffer_scan_reader.sv
// dffer_scan_reader
// -----------------
// Readback engine for a bank of user flops (dffer instances). A start strobe
// in IDLE copies the bank's Q outputs into a shadow register. The snapshot is
// then sent out serially, MSB first, over a valid/ready handshake. When
// PARITY_EN is set, one even-parity bit follows the data bits. The engine is
// the observation side of the flop bank and takes no part in writing it.
//
// Ports:
//   clk        rising-edge clock
//   R          synchronous active-high reset; abandons any frame in flight
//   start      request snapshot + readout (sampled only in IDLE)
//   Q_in       parallel Q outputs of the observed flop bank (WIDTH bits)
//   sout       serial data bit (registered)
//   sout_valid sout carries a bit awaiting transfer (registered)
//   sout_ready consumer accepts the bit at this edge
//   busy       high whenever the engine is not IDLE (registered)
//   done       one-cycle pulse after the last bit has been transferred
//
// Every output is a register loaded from the next-state values. This means
// no combinational path exists from start or sout_ready to any output. It
// also means the first bit is presented in the cycle right after the start
// edge.

module dffer_scan_reader #(
  parameter int WIDTH     = 8,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic             clk,
  input  logic             R,
  input  logic             start,
  input  logic [WIDTH-1:0] Q_in,
  output logic             sout,
  output logic             sout_valid,
  input  logic             sout_ready,
  output logic             busy,
  output logic             done
);

  // The counter must hold 0..WIDTH. It is only compared against WIDTH-1.
  localparam int CNT_W = (WIDTH < 2) ? 1 : $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] shadow_reg, shadow_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             par_reg, par_next;
  logic             sout_reg, sout_next;
  logic             sout_valid_reg, sout_valid_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic             xfer;

  // A bit leaves the engine only when the registered valid meets ready.
  assign xfer = sout_valid_reg & sout_ready;

  always_comb begin
    state_next      = state_reg;
    shadow_next     = shadow_reg;
    cnt_next        = cnt_reg;
    par_next        = par_reg;
    sout_next       = 1'b0;
    sout_valid_next = 1'b0;
    busy_next       = 1'b0;
    done_next       = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          shadow_next = Q_in;
          cnt_next    = '0;
          par_next    = 1'b0;
          state_next  = SHIFT;
        end
      end
      SHIFT: begin
        if (xfer) begin
          // The bit being transferred is the current shadow MSB.
          // It is folded into the parity before the shift drops it.
          par_next    = par_reg ^ shadow_reg[WIDTH-1];
          shadow_next = shadow_reg << 1;
          cnt_next    = cnt_reg + 1'b1;
          if (cnt_reg == LAST_IDX) begin
            state_next = PARITY_EN ? PAR : DONE;
          end
        end
      end
      PAR: begin
        if (xfer) begin
          state_next = DONE;
        end
      end
      DONE: begin
        // Single-cycle state. A start seen here is dropped, not queued.
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Registered outputs are derived from where the FSM is heading. This
    // way the output registers always describe the state being entered.
    case (state_next)
      SHIFT: begin
        sout_next       = shadow_next[WIDTH-1];
        sout_valid_next = 1'b1;
      end
      PAR: begin
        sout_next       = par_next;
        sout_valid_next = 1'b1;
      end
      DONE: begin
        done_next = 1'b1;
      end
      default: begin
        sout_next = 1'b0;
      end
    endcase
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk) begin
    if (R) begin
      state_reg      <= IDLE;
      shadow_reg     <= '0;
      cnt_reg        <= '0;
      par_reg        <= 1'b0;
      sout_reg       <= 1'b0;
      sout_valid_reg <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      shadow_reg     <= shadow_next;
      cnt_reg        <= cnt_next;
      par_reg        <= par_next;
      sout_reg       <= sout_next;
      sout_valid_reg <= sout_valid_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
    end
  end

  assign sout       = sout_reg;
  assign sout_valid = sout_valid_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;

endmodule
